// File: rtl/wb_irq_dispatcher_pkg.sv
// Shared types and helpers for the Wishbone interrupt dispatcher.
package wb_irq_dispatcher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISR,
        ST_DECODE,
        ST_DISPATCH,
        ST_WR_ACK,
        ST_HOLDOFF
    } state_e;

    localparam int VEC_W  = 5;
    localparam int SPUR_W = 8;

    function automatic logic [VEC_W-1:0] f_lowest_set(input logic [31:0] mask);
        logic [VEC_W-1:0] idx;
        logic             found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (mask[i] && !found) begin
                idx   = VEC_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_irq_dispatcher_irq_prio_enc.sv
// Combinational lowest-set-bit encoder over the masked ISR snapshot.
module irq_prio_enc
    import wb_irq_dispatcher_pkg::*;
#(
    parameter int g_num_irqs = 4
) (
    input  logic [g_num_irqs-1:0] mask_i,
    output logic [VEC_W-1:0]      idx_o,
    output logic                  any_o
);

    logic [31:0] mask_ext;

    always_comb begin
        mask_ext                 = '0;
        mask_ext[g_num_irqs-1:0] = mask_i;
    end

    assign idx_o = f_lowest_set(mask_ext);
    assign any_o = |mask_i;

endmodule

// File: rtl/wb_irq_dispatcher.sv
// Wishbone master that reads the EIC ISR, hands out the lowest pending source
// as a vector, and clears it by writing a one-hot mask once the handler is done.
module wb_irq_dispatcher
    import wb_irq_dispatcher_pkg::*;
#(
    parameter int g_num_irqs   = 4,
    parameter int g_addr_width = 2,
    parameter int g_isr_addr   = 3,
    parameter int g_timeout    = 255,
    parameter int g_holdoff    = 2
) (
    input  logic                    wb_clk_i,
    input  logic                    rst_n_i,
    input  logic                    irq_i,
    input  logic                    enable_i,
    output logic [g_addr_width-1:0] wbm_adr_o,
    output logic [31:0]             wbm_dat_o,
    input  logic [31:0]             wbm_dat_i,
    output logic                    wbm_cyc_o,
    output logic                    wbm_stb_o,
    output logic                    wbm_we_o,
    output logic [3:0]              wbm_sel_o,
    input  logic                    wbm_ack_i,
    output logic                    vec_valid_o,
    output logic [VEC_W-1:0]        vec_o,
    input  logic                    done_i,
    output logic                    err_o,
    output logic [SPUR_W-1:0]       spur_cnt_o
);

    localparam logic [g_addr_width-1:0] ISR_ADR = g_addr_width'(g_isr_addr);

    state_e                  state_q;
    logic                    cyc_q;
    logic                    we_q;
    logic [31:0]             wdat_q;
    logic [g_num_irqs-1:0]   isr_q;
    logic [VEC_W-1:0]        vec_q;
    logic                    vvalid_q;
    logic                    err_q;
    logic [SPUR_W-1:0]       spur_q;
    logic [31:0]             tmo_q;
    logic [31:0]             hold_q;

    logic [VEC_W-1:0]        enc_idx;
    logic                    enc_any;
    logic                    tmo_hit;
    logic                    unused_dat;

    // Bits above g_num_irqs are deliberately dropped when the ISR is captured.
    assign unused_dat = ^wbm_dat_i;

    irq_prio_enc #(
        .g_num_irqs (g_num_irqs)
    ) u_enc (
        .mask_i (isr_q),
        .idx_o  (enc_idx),
        .any_o  (enc_any)
    );

    assign tmo_hit = (g_timeout != 0) && (tmo_q == 32'(g_timeout - 1));

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            wdat_q   <= '0;
            isr_q    <= '0;
            vec_q    <= '0;
            vvalid_q <= 1'b0;
            err_q    <= 1'b0;
            spur_q   <= '0;
            tmo_q    <= '0;
            hold_q   <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (irq_i && enable_i) begin
                        state_q <= ST_RD_ISR;
                        tmo_q   <= '0;
                    end
                end
                // The cycle after entry raises cyc/stb; the ack is honoured only once they are up.
                ST_RD_ISR: begin
                    if (!cyc_q) begin
                        cyc_q <= 1'b1;
                        we_q  <= 1'b0;
                        tmo_q <= '0;
                    end else if (wbm_ack_i) begin
                        cyc_q   <= 1'b0;
                        isr_q   <= wbm_dat_i[g_num_irqs-1:0];
                        state_q <= ST_DECODE;
                    end else if (tmo_hit) begin
                        cyc_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                ST_DECODE: begin
                    if (enc_any) begin
                        vec_q    <= enc_idx;
                        vvalid_q <= 1'b1;
                        state_q  <= ST_DISPATCH;
                    end else begin
                        if (spur_q != {SPUR_W{1'b1}}) begin
                            spur_q <= spur_q + 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                end
                ST_DISPATCH: begin
                    if (done_i) begin
                        vvalid_q <= 1'b0;
                        wdat_q   <= 32'd1 << vec_q;
                        tmo_q    <= '0;
                        state_q  <= ST_WR_ACK;
                    end
                end
                ST_WR_ACK: begin
                    if (!cyc_q) begin
                        cyc_q <= 1'b1;
                        we_q  <= 1'b1;
                        tmo_q <= '0;
                    end else if (wbm_ack_i) begin
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        hold_q  <= '0;
                        state_q <= (g_holdoff == 0) ? ST_IDLE : ST_HOLDOFF;
                    end else if (tmo_hit) begin
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                // Gives the EIC time to drop irq after the clearing write.
                ST_HOLDOFF: begin
                    if (hold_q == 32'(g_holdoff - 1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        hold_q <= hold_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cyc_q   <= 1'b0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign wbm_adr_o   = cyc_q ? ISR_ADR : '0;
    assign wbm_dat_o   = wdat_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = 4'hf;
    assign vec_valid_o = vvalid_q;
    assign vec_o       = vec_q;
    assign err_o       = err_q;
    assign spur_cnt_o  = spur_q;

endmodule

// File: doc/wb_irq_dispatcher.md
# wb_irq_dispatcher

Wishbone master that services the embedded interrupt controller (EIC) in hardware. When the EIC raises its interrupt line, the dispatcher reads the EIC ISR and selects the lowest-numbered pending source. It then presents that source number as a vector to a downstream handler, and after the handler signals completion it acknowledges the source by writing a one-hot mask back to the ISR. It sits between the EIC slave port/`wb_irq_o` and a soft-CPU or sequencer that needs vectored, serialized interrupts.

## Interface
- `g_num_irqs`, 4: number of EIC sources, 1..32; ISR bits at or above this index are ignored.
- `g_addr_width`, 2: width of `wbm_adr_o`.
- `g_isr_addr`, 3: word address of the EIC ISR register.
- `g_timeout`, 255: maximum bus cycles to wait for `wbm_ack_i`; 0 disables the timeout.
- `g_holdoff`, 2: cycles to ignore `irq_i` after an ISR write.

Ports:
- `wb_clk_i` in 1: single clock.
- `rst_n_i` in 1: reset; synchronous, active-low.
- `irq_i` in 1: EIC `wb_irq_o`.
- `enable_i` in 1: dispatching allowed. Only sampled in IDLE.
- `wbm_adr_o` out `g_addr_width`: master address.
- `wbm_dat_o` out 32: master write data.
- `wbm_dat_i` in 32: master read data.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` out 1 each: bus control.
- `wbm_sel_o` out 4: byte select; always 4'hf.
- `wbm_ack_i` in 1: slave acknowledge.
- `vec_valid_o` out 1: a vector is pending for the handler.
- `vec_o` out 5: number of the pending source.
- `done_i` in 1: the handler has finished; only meaningful while `vec_valid_o` is high.
- `err_o` out 1: one-cycle pulse on a bus timeout.
- `spur_cnt_o` out 8: saturating count of spurious interrupts.

## Operation
States:
- **IDLE:** if `irq_i` and `enable_i` are both high, go to RD_ISR.
- **RD_ISR:** drive a read of `g_isr_addr` (`cyc=stb=1`, `we=0`).
  - On `wbm_ack_i`, capture `wbm_dat_i` masked to `g_num_irqs` bits and go to DECODE.
- **DECODE:** one cycle.
  - If the masked ISR is zero, increment `spur_cnt_o` (saturating at 255) and go to IDLE.
  - Otherwise latch `vec_o` as the index of the lowest set bit and go to DISPATCH.
- **DISPATCH:** hold `vec_valid_o` high and `vec_o` stable. On `done_i`, go to WR_ACK.
- **WR_ACK:** drive a write of `1 << vec_o` to `g_isr_addr` (`we=1`). On `wbm_ack_i`, go to HOLDOFF.
- **HOLDOFF:** wait `g_holdoff` cycles, then go to IDLE. This covers the registered deassert latency of the EIC.

Bus timeout:
- The timeout counter runs only in RD_ISR and WR_ACK and is cleared on entry to each.
- If it reaches `g_timeout` without an ack, drop `cyc/stb`, pulse `err_o`, and go to IDLE.
- A pending vector is discarded; the EIC source stays pending and is retried.

Boundary and corner cases:
- Multiple bits pending: the lowest index wins; the others are served on later passes because `irq_i` stays high.
- `enable_i` dropping outside IDLE: the current transaction completes.
- `done_i` outside DISPATCH: ignored.
- `wbm_ack_i` outside RD_ISR or WR_ACK: ignored.
- Reset mid-cycle: `cyc/stb` drop on the reset edge and the FSM returns to IDLE.

## Timing
- Reset values:
  - All bus outputs 0, except `wbm_sel_o` = 4'hf.
  - `vec_valid_o`=0, `vec_o`=0, `err_o`=0, `spur_cnt_o`=0.
  - State = IDLE.
- `irq_i` sampled high in IDLE at edge N: `wbm_cyc_o`/`wbm_stb_o` are high after edge N+1.
- Read latency:
  - Data is captured on the edge where `wbm_ack_i`=1.
  - `cyc/stb` are low the cycle after the ack.
  - With a zero-wait slave (ack one cycle after stb), `vec_valid_o` rises 4 cycles after `irq_i` is sampled.
- `done_i` at edge M: `vec_valid_o` is low and the write `cyc/stb/we` are high after edge M+1.
- Write ack at edge K: the next `irq_i` sample is at edge K+`g_holdoff`+1.
- Classic single-cycle Wishbone: `stb` is held until ack; one transfer per cycle assertion.

## Structure
Shared package `wb_irq_dispatcher_pkg` holds:
- the state enum;
- the vector width constant (5);
- the `spur_cnt` width constant (8);
- the function `f_lowest_set(mask) -> index`.

Sub-module `irq_prio_enc`: combinational lowest-set-bit encoder with a `g_num_irqs` parameter and an outputs `any` flag. The FSM and timeout counter live in the top module.

## Test plan
1. ISR reads 0x4, `done_i` pulsed 5 cycles after `vec_valid_o` rises → `vec_o`=2; ISR write data 0x4; `irq_i` drops; FSM returns to IDLE.
2. ISR reads 0x9 (bits 0 and 3) → two passes: `vec_o`=0 with write 0x1, then `vec_o`=3 with write 0x8.
3. `irq_i` high but ISR reads 0x0 → no `vec_valid_o`; `spur_cnt_o` increments by 1. After 300 such events, `spur_cnt_o`=255.
4. Slave never acks, `g_timeout`=16 → `err_o` pulses 16 cycles after `stb` rises; `cyc`=0; state returns to IDLE.
5. Assert `rst_n_i` low while in WR_ACK → the next edge has `cyc`=0 and `vec_valid_o`=0; after release, the still-pending source is re-dispatched.
6. `enable_i`=0 with `irq_i`=1 → no bus activity. Raising `enable_i` → read starts after the next edge.
